// File: rtl/seq_fsm_param.sv
// -----------------------------------------------------------------------------
// seq_fsm_param
// Three-state sequencer (IDLE -> PROCESS -> DONE -> IDLE) with a loadable
// down-counter, stall support and a programmable DONE hold time.
//
// Build option:
//   SEQ_ABORT_EN  - when defined, the abort input cancels an active sequence
//                   (PROCESS or DONE) and pulses aborted for one cycle.
//                   When undefined, abort is ignored and aborted is always 0.
//
// All outputs are registers or pure decodes of the state register, so no
// input has a combinational path to any output.
// -----------------------------------------------------------------------------
module seq_fsm_param #(
   parameter int CNT_W       = 8,   // counter / len / cycles_left width, 2..16
   parameter int DONE_CYCLES = 1    // cycles spent in DONE, 1..15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             stall,
   input  logic             abort,
   output logic             start_ack,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] cycles_left,
   output logic             aborted
);

   // State encodings; 2'b11 is unreachable and recovers to IDLE
   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_PROCESS = 2'b01;
   localparam logic [1:0] S_DONE    = 2'b10;

   // Last value of the DONE hold counter before returning to IDLE
   localparam logic [3:0]       HOLD_LAST = 4'(DONE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_hold;
   logic             r_start_ack;
   logic             r_aborted;

   logic [1:0]       w_state_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic [3:0]       w_hold_next;
   logic             w_start_ack_next;
   logic             w_aborted_next;
   logic             w_abort_req;

`ifdef SEQ_ABORT_EN
   assign w_abort_req = abort;
`else
   // Abort is not part of this build; the input is deliberately left unused
   logic w_abort_unused;
   assign w_abort_unused = abort;
   assign w_abort_req    = 1'b0;
`endif

   // Next-state, counter, hold-counter and pulse decode
   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_hold_next      = r_hold;
      w_start_ack_next = 1'b0;
      w_aborted_next   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Abort is meaningless here; a start is accepted regardless
            if (start) begin
               w_start_ack_next = 1'b1;
               w_hold_next      = 4'd0;
               if (len == '0) begin
                  w_state_next = S_DONE;
                  w_cnt_next   = '0;
               end else begin
                  w_state_next = S_PROCESS;
                  w_cnt_next   = len;
               end
            end
         end
         S_PROCESS: begin
            // Abort outranks both stall and completion
            if (w_abort_req) begin
               w_state_next   = S_IDLE;
               w_cnt_next     = '0;
               w_hold_next    = 4'd0;
               w_aborted_next = 1'b1;
            end else if (!stall) begin
               // <= rather than == keeps the counter from ever wrapping
               if (r_cnt <= CNT_ONE) begin
                  w_state_next = S_DONE;
                  w_cnt_next   = '0;
                  w_hold_next  = 4'd0;
               end else begin
                  w_cnt_next = r_cnt - CNT_ONE;
               end
            end
         end
         S_DONE: begin
            if (w_abort_req) begin
               w_state_next   = S_IDLE;
               w_cnt_next     = '0;
               w_hold_next    = 4'd0;
               w_aborted_next = 1'b1;
            end else if (r_hold >= HOLD_LAST) begin
               w_state_next = S_IDLE;
               w_hold_next  = 4'd0;
            end else begin
               w_hold_next = r_hold + 4'd1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_hold_next  = 4'd0;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously by rst_n
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_hold      <= 4'd0;
         r_start_ack <= 1'b0;
         r_aborted   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_hold      <= w_hold_next;
         r_start_ack <= w_start_ack_next;
         r_aborted   <= w_aborted_next;
      end
   end

   // Moore outputs: registers or state decodes only
   assign start_ack   = r_start_ack;
   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign cycles_left = r_cnt;
   assign aborted     = r_aborted;

endmodule

// File: tb/tb_seq_fsm_param.sv
// -----------------------------------------------------------------------------
// tb_seq_fsm_param
// Directed-vector bench for seq_fsm_param (CNT_W=4, DONE_CYCLES=2).
// Each step drives the inputs for one cycle and queues the outputs expected
// during that same cycle; a monitor on the falling edge pops and compares.
// Expectations for the abort scenarios follow SEQ_ABORT_EN.
// -----------------------------------------------------------------------------
module tb_seq_fsm_param;

   localparam int CNT_W       = 4;
   localparam int DONE_CYCLES = 2;

   logic             clk   = 1'b1;
   logic             rst_n = 1'b1;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             stall;
   logic             abort;
   logic             start_ack;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] cycles_left;
   logic             aborted;

   typedef struct {
      string      name;
      logic       ack;
      logic       busy;
      logic       done;
      logic [3:0] left;
      logic       abt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   seq_fsm_param #(.CNT_W(CNT_W), .DONE_CYCLES(DONE_CYCLES)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .len        (len),
      .stall      (stall),
      .abort      (abort),
      .start_ack  (start_ack),
      .busy       (busy),
      .done       (done),
      .cycles_left(cycles_left),
      .aborted    (aborted)
   );

   // Rising edges at 10, 20, ...; falling edges at 5, 15, ...
   always #5 clk = ~clk;

   // Monitor: compare every queued expectation at the falling edge
   always @(negedge clk) begin
      exp_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         n_checks++;
         if ({start_ack, busy, done, cycles_left, aborted} !==
             {e.ack, e.busy, e.done, e.left, e.abt}) begin
            n_fail++;
            $display("FAIL %s: got ack=%b busy=%b done=%b left=%0d abt=%b, want ack=%b busy=%b done=%b left=%0d abt=%b",
                     e.name, start_ack, busy, done, cycles_left, aborted,
                     e.ack, e.busy, e.done, e.left, e.abt);
         end else begin
            $display("ok   %s: ack=%b busy=%b done=%b left=%0d abt=%b",
                     e.name, start_ack, busy, done, cycles_left, aborted);
         end
      end
   end

   // One cycle: drive inputs after the rising edge, queue this cycle's outputs,
   // optionally pulse rst_n low between edges
   task automatic step(input string nm,
                       input logic st, input logic [3:0] ln, input logic sl,
                       input logic ab, input logic rp,
                       input logic e_ack, input logic e_busy, input logic e_done,
                       input logic [3:0] e_left, input logic e_abt);
      @(posedge clk);
      #1;
      start = st;
      len   = ln;
      stall = sl;
      abort = ab;
      q.push_back('{nm, e_ack, e_busy, e_done, e_left, e_abt});
      if (rp) begin
         #1 rst_n = 1'b0;
         #2 rst_n = 1'b1;
      end
   endtask

   initial begin
      start = 1'b0;
      len   = 4'd0;
      stall = 1'b0;
      abort = 1'b0;

      // Reset state, checked at t=5 while rst_n is still low
      #1 rst_n = 1'b0;
      q.push_back('{"reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
      #6;
      // Release and present start before the first rising edge
      rst_n = 1'b1;
      start = 1'b1;
      len   = 4'd3;

      // A: len=3, no stall
      step("A_ack",   0, 0, 0, 0, 0,  1, 1, 0, 4'd3, 0);
      step("A_cnt2",  0, 0, 0, 0, 0,  0, 1, 0, 4'd2, 0);
      step("A_cnt1",  0, 0, 0, 0, 0,  0, 1, 0, 4'd1, 0);
      step("A_done0", 0, 0, 0, 0, 0,  0, 1, 1, 4'd0, 0);
      step("A_done1", 0, 0, 0, 0, 0,  0, 1, 1, 4'd0, 0);
      // B: len=0 goes straight to DONE
      step("B_idle",  1, 0, 0, 0, 0,  0, 0, 0, 4'd0, 0);
      step("B_done0", 0, 0, 0, 0, 0,  1, 1, 1, 4'd0, 0);
      step("B_done1", 0, 0, 0, 0, 0,  0, 1, 1, 4'd0, 0);
      // C: len=4 with a two-cycle stall while cycles_left=2
      step("C_idle",  1, 4, 0, 0, 0,  0, 0, 0, 4'd0, 0);
      step("C_ack",   0, 4, 0, 0, 0,  1, 1, 0, 4'd4, 0);
      step("C_cnt3",  0, 4, 0, 0, 0,  0, 1, 0, 4'd3, 0);
      step("C_stl0",  0, 4, 1, 0, 0,  0, 1, 0, 4'd2, 0);
      step("C_stl1",  0, 4, 1, 0, 0,  0, 1, 0, 4'd2, 0);
      step("C_cnt2",  0, 4, 0, 0, 0,  0, 1, 0, 4'd2, 0);
      step("C_cnt1",  0, 4, 0, 0, 0,  0, 1, 0, 4'd1, 0);
      step("C_done0", 0, 4, 0, 0, 0,  0, 1, 1, 4'd0, 0);
      step("C_done1", 0, 4, 0, 0, 0,  0, 1, 1, 4'd0, 0);
      // D: start held high, len=2, back-to-back sequences
      step("D_idle",  1, 2, 0, 0, 0,  0, 0, 0, 4'd0, 0);
      step("D_ack",   1, 2, 0, 0, 0,  1, 1, 0, 4'd2, 0);
      step("D_cnt1",  1, 2, 0, 0, 0,  0, 1, 0, 4'd1, 0);
      step("D_done0", 1, 2, 0, 0, 0,  0, 1, 1, 4'd0, 0);
      step("D_done1", 1, 2, 0, 0, 0,  0, 1, 1, 4'd0, 0);
      step("D_idle2", 1, 2, 0, 0, 0,  0, 0, 0, 4'd0, 0);
      step("D_ack2",  0, 2, 0, 0, 0,  1, 1, 0, 4'd2, 0);
      step("D_cnt1b", 0, 2, 0, 0, 0,  0, 1, 0, 4'd1, 0);
      step("D_dn0b",  0, 2, 0, 0, 0,  0, 1, 1, 4'd0, 0);
      step("D_dn1b",  0, 2, 0, 0, 0,  0, 1, 1, 4'd0, 0);
      // E: abort on the cycle cycles_left=1
      step("E_idle",  1, 3, 0, 0, 0,  0, 0, 0, 4'd0, 0);
      step("E_ack",   0, 3, 0, 0, 0,  1, 1, 0, 4'd3, 0);
      step("E_cnt2",  0, 3, 0, 0, 0,  0, 1, 0, 4'd2, 0);
      step("E_cnt1",  0, 3, 0, 1, 0,  0, 1, 0, 4'd1, 0);
`ifdef SEQ_ABORT_EN
      step("E_abt",   0, 3, 0, 0, 0,  0, 0, 0, 4'd0, 1);
`else
      step("E_done0", 0, 3, 0, 0, 0,  0, 1, 1, 4'd0, 0);
      step("E_done1", 0, 3, 0, 0, 0,  0, 1, 1, 4'd0, 0);
`endif
      // F: start with abort high in IDLE, then abort together with stall
      step("F_idle",  1, 1, 0, 1, 0,  0, 0, 0, 4'd0, 0);
      step("F_ack",   0, 1, 1, 1, 0,  1, 1, 0, 4'd1, 0);
`ifdef SEQ_ABORT_EN
      step("F_abt",   0, 1, 0, 0, 0,  0, 0, 0, 4'd0, 1);
`else
      step("F_stall", 0, 1, 0, 0, 0,  0, 1, 0, 4'd1, 0);
      step("F_done0", 0, 1, 0, 0, 0,  0, 1, 1, 4'd0, 0);
      step("F_done1", 0, 1, 0, 0, 0,  0, 1, 1, 4'd0, 0);
`endif
      // G: asynchronous reset mid-PROCESS, then a normal sequence
      step("G_idle",  1, 5, 0, 0, 0,  0, 0, 0, 4'd0, 0);
      step("G_ack",   0, 5, 0, 0, 0,  1, 1, 0, 4'd5, 0);
      step("G_cnt4",  0, 5, 0, 0, 0,  0, 1, 0, 4'd4, 0);
      step("G_rst",   0, 5, 0, 0, 1,  0, 0, 0, 4'd0, 0);
      step("G_idle2", 1, 2, 0, 0, 0,  0, 0, 0, 4'd0, 0);
      step("G_ack2",  0, 2, 0, 0, 0,  1, 1, 0, 4'd2, 0);
      step("G_cnt1",  0, 2, 0, 0, 0,  0, 1, 0, 4'd1, 0);
      step("G_done0", 0, 2, 0, 0, 0,  0, 1, 1, 4'd0, 0);
      step("G_done1", 0, 2, 0, 0, 0,  0, 1, 1, 4'd0, 0);
      // H: all-ones len gives 15 processing cycles, no wrap
      step("H_idle",  1, 15, 0, 0, 0, 0, 0, 0, 4'd0, 0);
      step("H_ack",   0, 15, 0, 0, 0, 1, 1, 0, 4'd15, 0);
      for (int i = 14; i >= 1; i--) begin
         step("H_cnt", 0, 15, 0, 0, 0, 0, 1, 0, 4'(i), 0);
      end
      step("H_done0", 0, 15, 0, 0, 0, 0, 1, 1, 4'd0, 0);
      step("H_done1", 0, 15, 0, 0, 0, 0, 1, 1, 4'd0, 0);
      step("H_end",   0, 15, 0, 0, 0, 0, 0, 0, 4'd0, 0);

      // Let the monitor drain the queue, bounded
      for (int k = 0; k < 8 && q.size() != 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
